// File: rtl/alu_sequencer_pkg.sv
// Shared constants and types for the 4-bit ALU sequencer.
// Op codes, FSM states and datapath widths.
package alu_sequencer_pkg;

  localparam int WIDTH     = 4;
  localparam int MUL_STEPS = 4;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_MUL  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MUL   = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative 4x4 shift-add multiplier with start/done handshake.
// done rises combinationally on the last step, with the final product.
module alu_shift_add_mul
  import alu_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] pp_nx;
  logic [WIDTH-1:0]   mplier;
  logic [3:0]         cnt;
  logic               run;

  assign pp_nx   = mplier[0] ? pp + mcand : pp;
  assign done    = run && (cnt == 4'(MUL_STEPS - 1));
  assign product = pp_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      pp     <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      pp     <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      pp     <= pp_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control stage feeding the accumulator.
// One write strobe per accepted request; CARRY/ZERO held between results.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ACC,
  output logic [WIDTH-1:0] W_DATA,
  output logic             S,
  output logic             BUSY,
  output logic             DONE,
  output logic             CARRY,
  output logic             ZERO
);

  state_t state;
  state_t state_nx;

  op_t              op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     alu_wide;

  assign accept    = (state == ST_IDLE) && START;
  assign mul_start = accept && (op_t'(OP) == OP_MUL);

  alu_shift_add_mul u_mul (
    .clk     (CLK),
    .rst     (RST),
    .start   (mul_start),
    .a       (ACC),
    .b       (B),
    .done    (mul_done),
    .product (product)
  );

  // Bit WIDTH is carry/borrow; logic ops leave it 0.
  always_comb begin
    alu_wide = '0;
    unique case (op_q)
      OP_LOAD: alu_wide = {1'b0, b_q};
      OP_ADD:  alu_wide = {1'b0, acc_q} + {1'b0, b_q};
      OP_SUB:  alu_wide = {1'b0, acc_q} - {1'b0, b_q};
      OP_AND:  alu_wide = {1'b0, acc_q & b_q};
      OP_OR:   alu_wide = {1'b0, acc_q | b_q};
      OP_XOR:  alu_wide = {1'b0, acc_q ^ b_q};
      OP_SHL:  alu_wide = {acc_q, 1'b0};
      OP_MUL:  alu_wide = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    BUSY     = (state != ST_IDLE);
    S        = (state == ST_WRITE);
    DONE     = (state == ST_WRITE);
    unique case (state)
      ST_IDLE:
        if (START)
          state_nx = (op_t'(OP) == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC:  state_nx = ST_WRITE;
      ST_MUL:   if (mul_done) state_nx = ST_WRITE;
      ST_WRITE: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q   <= OP_LOAD;
      b_q    <= '0;
      acc_q  <= '0;
      W_DATA <= '0;
      CARRY  <= 1'b0;
      ZERO   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op_t'(OP);
        b_q   <= B;
        acc_q <= ACC;
      end
      if (state == ST_EXEC) begin
        W_DATA <= alu_wide[WIDTH-1:0];
        CARRY  <= alu_wide[WIDTH];
        ZERO   <= (alu_wide[WIDTH-1:0] == '0);
      end
      if (state == ST_MUL && mul_done) begin
        W_DATA <= product[WIDTH-1:0];
        CARRY  <= |product[2*WIDTH-1:WIDTH];
        ZERO   <= (product[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
// Hand-computed vectors; outputs sampled 1ns after the rising edge.
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [2:0] OP = 3'd0;
  logic [3:0] B = 4'd0;
  logic [3:0] ACC = 4'd0;
  logic [3:0] W_DATA;
  logic       S;
  logic       BUSY;
  logic       DONE;
  logic       CARRY;
  logic       ZERO;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 CLK = ~CLK;

  alu_sequencer dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .OP     (OP),
    .B      (B),
    .ACC    (ACC),
    .W_DATA (W_DATA),
    .S      (S),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .CARRY  (CARRY),
    .ZERO   (ZERO)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 20) begin
      step();
      n++;
    end
    chk("idle_timeout", 8'(BUSY), 8'h0);
  endtask

  // START edge, then operands scrambled so the snapshot is exercised.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [3:0] acc, input logic [3:0] b,
                       input logic [3:0] ew, input logic ec,
                       input logic ez, input int lat);
    OP = op;
    ACC = acc;
    B = b;
    START = 1'b1;
    step();
    START = 1'b0;
    OP = ~op;
    ACC = ~acc;
    B = ~b;
    for (int c = 1; c <= lat; c++) begin
      chk({tag, "_busy"}, 8'(BUSY), 8'h1);
      chk({tag, "_s"}, 8'(S), 8'(c == lat));
      chk({tag, "_done"}, 8'(DONE), 8'(c == lat));
      if (c < lat) step();
    end
    chk({tag, "_w"}, 8'(W_DATA), 8'(ew));
    chk({tag, "_c"}, 8'(CARRY), 8'(ec));
    chk({tag, "_z"}, 8'(ZERO), 8'(ez));
    step();
    chk({tag, "_s_after"}, 8'(S), 8'h0);
    chk({tag, "_busy_after"}, 8'(BUSY), 8'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w"}, 8'(W_DATA), 8'h0);
    chk({tag, "_s"}, 8'(S), 8'h0);
    chk({tag, "_busy"}, 8'(BUSY), 8'h0);
    chk({tag, "_done"}, 8'(DONE), 8'h0);
    chk({tag, "_c"}, 8'(CARRY), 8'h0);
    chk({tag, "_z"}, 8'(ZERO), 8'h0);
  endtask

  initial begin
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    chk_all_zero("rst");

    do_op("add", 3'b001, 4'd9, 4'd8, 4'h1, 1'b1, 1'b0, 2);
    do_op("sub_b", 3'b010, 4'd3, 4'd5, 4'hE, 1'b1, 1'b0, 2);
    do_op("sub_z", 3'b010, 4'd5, 4'd5, 4'h0, 1'b0, 1'b1, 2);
    do_op("and", 3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 2);
    do_op("or", 3'b100, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 2);
    do_op("xor", 3'b101, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 2);
    do_op("load", 3'b000, 4'h3, 4'h7, 4'h7, 1'b0, 1'b0, 2);
    do_op("mul15", 3'b111, 4'd3, 4'd5, 4'hF, 1'b0, 1'b0, 5);
    do_op("mul21", 3'b111, 4'd7, 4'd3, 4'h5, 1'b1, 1'b0, 5);
    do_op("mul0", 3'b111, 4'd0, 4'd9, 4'h0, 1'b0, 1'b1, 5);
    do_op("shl", 3'b110, 4'd9, 4'd0, 4'h2, 1'b1, 1'b0, 2);

    // START pulses in MUL and in WRITE must be dropped.
    OP = 3'b111;
    ACC = 4'd7;
    B = 4'd3;
    START = 1'b1;
    step();
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      if (S) begin
        pulses++;
        chk("ign_pos", 8'(c), 8'd5);
        chk("ign_w", 8'(W_DATA), 8'h5);
      end
      if (c == 6) chk("ign_busy_fall", 8'(BUSY), 8'h0);
      START = (c == 2 || c == 5);
      OP = 3'b000;
      B = 4'hA;
      step();
    end
    START = 1'b0;
    chk("ign_pulses", 8'(pulses), 8'd1);

    // Reset in the second MUL cycle.
    OP = 3'b111;
    ACC = 4'd3;
    B = 4'd5;
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_all_zero("midrst");
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (S) pulses++;
      step();
    end
    chk("midrst_pulses", 8'(pulses), 8'd0);

    // START held high: one strobe every third cycle.
    OP = 3'b001;
    ACC = 4'd1;
    B = 4'd1;
    START = 1'b1;
    step();
    for (int c = 1; c <= 9; c++) begin
      chk("b2b_s", 8'(S), 8'(c % 3 == 2));
      if (S) chk("b2b_w", 8'(W_DATA), 8'h2);
      step();
    end
    START = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
